// File: rtl/calc_seq_ctrl.sv
// ============================================================================
// Module  : calc_seq_ctrl
// Brief   : Sequential valid/ready front-end for the 4-bit calculator core.
//           Optional sticky overflow flag enabled by CALC_STICKY_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_chain,
  output logic [2:0]       core_op,
  output logic [3:0]       core_a,
  output logic [3:0]       core_b,
  input  logic [3:0]       core_r,
  input  logic             core_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_r,
  output logic             out_ovf,
`ifdef CALC_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             sticky_ovf,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [2:0]       r_core_op;
  logic [3:0]       r_core_a;
  logic [3:0]       r_core_b;
  logic [3:0]       r_out_r;
  logic             r_out_ovf;
  logic [3:0]       r_last_r;
  logic [CNT_W-1:0] r_op_count;

  logic [3:0]       w_a_sel;
  logic             w_capture;

  // Chained requests take the last captured result, regardless of its overflow.
  assign w_a_sel   = in_chain ? r_last_r : in_a;
  assign w_capture = (r_state == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_core_op   <= 3'd0;
      r_core_a    <= 4'd0;
      r_core_b    <= 4'd0;
      r_out_r     <= 4'd0;
      r_out_ovf   <= 1'b0;
      r_last_r    <= 4'd0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_core_op  <= in_op;
            r_core_a   <= w_a_sel;
            r_core_b   <= in_b;
            r_in_ready <= 1'b0;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_out_r     <= core_r;
          r_out_ovf   <= core_ovf;
          r_last_r    <= core_r;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_op_count  <= r_op_count + CNT_W'(1);
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CALC_STICKY_OVF_EN
  logic r_sticky_ovf;

  // A set on the capture edge overrides a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sticky_ovf <= 1'b0;
    end else if (w_capture && core_ovf) begin
      r_sticky_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_sticky_ovf <= 1'b0;
    end
  end

  assign sticky_ovf = r_sticky_ovf;
`else
  logic w_capture_unused;
  assign w_capture_unused = w_capture;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign core_op   = r_core_op;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign out_r     = r_out_r;
  assign out_ovf   = r_out_ovf;
  assign op_count  = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_calc_seq_ctrl.sv
// ============================================================================
// Module  : tb_calc_seq_ctrl
// Brief   : Directed self-checking bench for calc_seq_ctrl with a core model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_seq_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [3:0]       in_a;
  logic [3:0]       in_b;
  logic             in_chain;
  logic [2:0]       core_op;
  logic [3:0]       core_a;
  logic [3:0]       core_b;
  logic [3:0]       core_r;
  logic             core_ovf;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_r;
  logic             out_ovf;
  logic [CNT_W-1:0] op_count;
`ifdef CALC_STICKY_OVF_EN
  logic             ovf_clr;
  logic             sticky_ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  calc_seq_ctrl #(.CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_chain  (in_chain),
    .core_op   (core_op),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_r    (core_r),
    .core_ovf  (core_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_ovf   (out_ovf),
`ifdef CALC_STICKY_OVF_EN
    .ovf_clr   (ovf_clr),
    .sticky_ovf(sticky_ovf),
`endif
    .op_count  (op_count)
  );

  // Behavioural model of the combinational calculator core.
  logic [4:0] w_sum;
  always_comb begin
    w_sum    = 5'd0;
    core_r   = 4'd0;
    core_ovf = 1'b0;
    case (core_op)
      3'b000, 3'b100: begin
        w_sum    = {core_a[3], core_a} + {core_b[3], core_b};
        core_r   = w_sum[3:0];
        core_ovf = w_sum[4] ^ w_sum[3];
      end
      3'b001: begin
        w_sum    = {core_a[3], core_a} - {core_b[3], core_b};
        core_r   = w_sum[3:0];
        core_ovf = w_sum[4] ^ w_sum[3];
      end
      3'b101: begin
        w_sum    = {core_b[3], core_b} - {core_a[3], core_a};
        core_r   = w_sum[3:0];
        core_ovf = w_sum[4] ^ w_sum[3];
      end
      3'b010, 3'b011: begin
        core_r   = core_b[3] ? (4'd0 - core_b) : core_b;
        core_ovf = (core_b == 4'b1000);
      end
      default: begin
        core_r   = core_a[3] ? (4'd0 - core_a) : core_a;
        core_ovf = (core_a == 4'b1000);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with out_ready=1; called one step after a clock edge in IDLE.
  task automatic do_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic chain, input logic [3:0] exp_core_a,
                       input logic [3:0] exp_r, input logic exp_ovf);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_chain  = chain;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("exec_in_ready", in_ready, 0);
    check("exec_out_valid", out_valid, 0);
    check("core_op", core_op, op);
    check("core_a", core_a, exp_core_a);
    check("core_b", core_b, b);
    tick();
    check("done_out_valid", out_valid, 1);
    check("done_in_ready", in_ready, 0);
    check("out_r", out_r, exp_r);
    check("out_ovf", out_ovf, exp_ovf);
    tick();
    exp_cnt = exp_cnt + 1'b1;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("op_count", op_count, exp_cnt);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst     = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 4'd0;
    in_b      = 4'd0;
    in_chain  = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = '0;
`ifdef CALC_STICKY_OVF_EN
    ovf_clr   = 1'b0;
`endif
    apply_reset();

    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_core_op", core_op, 0);
    check("rst_core_a", core_a, 0);
    check("rst_core_b", core_b, 0);
    check("rst_op_count", op_count, 0);
`ifdef CALC_STICKY_OVF_EN
    check("rst_sticky", sticky_ovf, 0);
`endif

    // Chain as the very first request uses A=0.
    do_op(3'b000, 4'b0111, 4'b0011, 1'b1, 4'b0000, 4'b0011, 1'b0);

    do_op(3'b000, 4'b0011, 4'b0100, 1'b0, 4'b0011, 4'b0111, 1'b0);
    do_op(3'b001, 4'b1111, 4'b0010, 1'b1, 4'b0111, 4'b0101, 1'b0);
    do_op(3'b000, 4'b0101, 4'b0100, 1'b0, 4'b0101, 4'b1001, 1'b1);
    // Chain through an overflowed result: 1001 + 0001 = 1010.
    do_op(3'b000, 4'b0000, 4'b0001, 1'b1, 4'b1001, 4'b1010, 1'b0);
    do_op(3'b110, 4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1);
    do_op(3'b111, 4'b1101, 4'b0000, 1'b0, 4'b1101, 4'b0011, 1'b0);
    do_op(3'b010, 4'b0000, 4'b1101, 1'b0, 4'b0000, 4'b0011, 1'b0);
    do_op(3'b011, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1);
    do_op(3'b100, 4'b0011, 4'b0010, 1'b0, 4'b0011, 4'b0101, 1'b0);
    do_op(3'b101, 4'b0011, 4'b0001, 1'b0, 4'b0011, 4'b1110, 1'b0);
    do_op(3'b001, 4'b1000, 4'b0001, 1'b0, 4'b1000, 4'b0111, 1'b1);

    // Backpressure: result held, new requests ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 3'b000;
    in_a      = 4'b0010;
    in_b      = 4'b0001;
    in_chain  = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_out_valid", out_valid, 1);
    check("bp_out_r", out_r, 4'b0011);
    in_valid = 1'b1;
    in_op    = 3'b001;
    in_a     = 4'b0111;
    in_b     = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_r", out_r, 4'b0011);
      check("bp_hold_ovf", out_ovf, 0);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_cnt", op_count, exp_cnt);
      check("bp_hold_core_a", core_a, 4'b0010);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    exp_cnt = exp_cnt + 1'b1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_cnt", op_count, exp_cnt);
    tick();
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_core_op", core_op, 3'b000);

    // Reset in EXEC discards the request.
    do_op(3'b000, 4'b0011, 4'b0100, 1'b0, 4'b0011, 4'b0111, 1'b0);
    in_valid = 1'b1;
    in_op    = 3'b000;
    in_a     = 4'b0001;
    in_b     = 4'b0001;
    tick();
    check("mid_exec_ready", in_ready, 0);
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = '0;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_r", out_r, 0);
    check("mrst_out_ovf", out_ovf, 0);
    check("mrst_core_op", core_op, 0);
    check("mrst_core_a", core_a, 0);
    check("mrst_core_b", core_b, 0);
    check("mrst_op_count", op_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst_no_valid", out_valid, 0);
    end
    do_op(3'b000, 4'b0101, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0);

    // Counter wrap after 256 completions.
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      do_op(3'b000, 4'(i), 4'b0000, 1'b0, 4'(i), 4'(i), 1'b0);
    end
    check("cnt_wrap", op_count, 0);

`ifdef CALC_STICKY_OVF_EN
    apply_reset();
    check("sticky_rst", sticky_ovf, 0);
    do_op(3'b000, 4'b0101, 4'b0100, 1'b0, 4'b0101, 4'b1001, 1'b1);
    check("sticky_set", sticky_ovf, 1);
    do_op(3'b000, 4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0010, 1'b0);
    check("sticky_hold", sticky_ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("sticky_clr", sticky_ovf, 0);
    ovf_clr   = 1'b1;
    in_valid  = 1'b1;
    in_op     = 3'b000;
    in_a      = 4'b0101;
    in_b      = 4'b0100;
    in_chain  = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("sticky_set_wins", sticky_ovf, 1);
    check("sticky_out_r", out_r, 4'b1001);
    ovf_clr = 1'b0;
    tick();
    check("sticky_after_hs", sticky_ovf, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sticky_rst_clr", sticky_ovf, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
